key_irq_ctrl: RTL and testbench

KEY_IRQ_CTRL -- requirements
Module: key_irq_ctrl

---
 rtl/key_irq_pkg.sv | 37 +++
 rtl/key_fifo.sv | 72 +++++++
 rtl/key_irq_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_key_irq_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_irq_pkg.sv
// Shared constants and types for the keyboard interrupt controller.
package key_irq_pkg;

   // Default bus map
   localparam logic [63:0] ART_BASE_DEF  = 64'h8000_0000;
   localparam logic [63:0] KEY_BASE_DEF  = 64'h8000_0010;
   localparam logic [63:0] STAT_BASE_DEF = 64'h8000_0018;

   // Interrupt vector encodings seen by the core
   localparam logic [3:0] IRQ_NONE = 4'd0;
   localparam logic [3:0] IRQ_KEY  = 4'd1;

   // Status register bit positions
   localparam int STAT_EMPTY_BIT = 0;
   localparam int STAT_OVF_BIT   = 1;
   localparam int CLR_OVF_BIT    = 1;

   // Interrupt handshake states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_ACK  = 2'd2
   } irq_state_e;

   // Status word layout: count in [15:8], ovf in [1], empty in [0]
   function automatic logic [63:0] pack_status(input logic [7:0] count,
                                               input logic       ovf,
                                               input logic       empty);
      logic [63:0] w_word;
      w_word                 = '0;
      w_word[15:8]           = count;
      w_word[STAT_OVF_BIT]   = ovf;
      w_word[STAT_EMPTY_BIT] = empty;
      return w_word;
   endfunction

endpackage

// File: rtl/key_fifo.sv
// Keycode FIFO. Push is accepted when not full, or when full together with
// a pop so the freed slot is reused in the same cycle. Pops on an empty
// FIFO are ignored. Head reads as zero while empty.
module key_fifo
   import key_irq_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [WIDTH-1:0]           i_data,
   output logic [WIDTH-1:0]           o_head,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_push;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_pop   = i_pop & ~w_empty;
   assign w_push  = i_push & (~w_full | w_pop);

   // Storage array; no reset needed since empty masks the head
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers and occupancy; pointers wrap naturally because DEPTH is 2^AW
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
   assign o_full  = w_full;
   assign o_empty = w_empty;
   assign o_count = r_count;

endmodule

// File: rtl/key_irq_ctrl.sv
// Keyboard interrupt controller: buffers keycodes, raises an interrupt to
// the core while keys are waiting, exposes key/status registers on the core
// bus and forwards character writes to the art output port.
//
// Interrupt FSM
//   state   | meaning
//   --------+--------------------------------------------------------
//   ST_IDLE | no interrupt raised; waits for a non-empty FIFO
//   ST_PEND | interrupt_vector = IRQ_KEY; waits for interrupt_done=1
//   ST_ACK  | core acknowledged; waits for interrupt_done to drop
module key_irq_ctrl
   import key_irq_pkg::*;
#(
   parameter int          DEPTH     = 8,
   parameter logic [63:0] KEY_BASE  = KEY_BASE_DEF,
   parameter logic [63:0] ART_BASE  = ART_BASE_DEF,
   parameter logic [63:0] STAT_BASE = STAT_BASE_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        key_valid,
   input  logic [7:0]  key_data,
   output logic [3:0]  interrupt_vector,
   input  logic        interrupt_done,
   input  logic [63:0] bus_address,
   input  logic        bus_read_enable,
   input  logic        bus_write_enable,
   input  logic [63:0] bus_write_data,
   output logic [63:0] bus_read_data,
   output logic        art_valid,
   output logic [7:0]  art_data
);

   localparam int CW = $clog2(DEPTH) + 1;

   // Bus strobe edge tracking
   logic          r_rd_prev;
   logic          r_wr_prev;
   logic          w_rd_rise;
   logic          w_wr_rise;

   // Address decode and single-shot accesses
   logic          w_key_hit;
   logic          w_art_hit;
   logic          w_stat_hit;
   logic          w_key_rd_acc;
   logic          w_art_wr_acc;
   logic          w_stat_wr_acc;

   // FIFO interface
   logic [7:0]    w_head;
   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_count;
   logic [7:0]    w_count8;
   logic          w_pop_eff;

   // Overflow tracking
   logic          r_ovf;
   logic          w_drop;
   logic          w_ovf_clr;

   // Interrupt FSM and art output
   irq_state_e    r_state;
   logic [3:0]    r_irq_vec;
   logic          r_art_valid;
   logic [7:0]    r_art_data;

   // Only the low byte and the clear bit of write data are meaningful
   logic          w_unused_wdata;
   assign w_unused_wdata = ^bus_write_data[63:8];

   assign w_key_hit  = (bus_address == KEY_BASE);
   assign w_art_hit  = (bus_address == ART_BASE);
   assign w_stat_hit = (bus_address == STAT_BASE);

   // A held strobe produces exactly one action: only its first cycle counts
   assign w_rd_rise = bus_read_enable  & ~r_rd_prev;
   assign w_wr_rise = bus_write_enable & ~r_wr_prev;

   assign w_key_rd_acc  = w_rd_rise & w_key_hit;
   assign w_art_wr_acc  = w_wr_rise & w_art_hit;
   assign w_stat_wr_acc = w_wr_rise & w_stat_hit;

   // Mirror the FIFO's own pop qualification so the drop decision matches
   assign w_pop_eff = w_key_rd_acc & ~w_empty;
   assign w_drop    = key_valid & w_full & ~w_pop_eff;
   assign w_ovf_clr = w_stat_wr_acc & bus_write_data[CLR_OVF_BIT];

   assign w_count8  = 8'(w_count);

   key_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_key_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (key_valid),
      .i_pop   (w_key_rd_acc),
      .i_data  (key_data),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // Previous-cycle strobe flags for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_prev <= 1'b0;
         r_wr_prev <= 1'b0;
      end else begin
         r_rd_prev <= bus_read_enable;
         r_wr_prev <= bus_write_enable;
      end
   end

   // Sticky overflow flag; a drop in the same cycle as a clear keeps it set
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

   // Combinational read mux; key reads show the head the same cycle it pops
   always_comb begin
      bus_read_data = '0;
      if (bus_read_enable) begin
         if (w_key_hit) begin
            bus_read_data = {56'b0, w_head};
         end else if (w_stat_hit) begin
            bus_read_data = pack_status(w_count8, r_ovf, w_empty);
         end
      end
   end

   // Interrupt handshake FSM with registered vector
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_irq_vec <= IRQ_NONE;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  r_state   <= ST_PEND;
                  r_irq_vec <= IRQ_KEY;
               end else begin
                  r_irq_vec <= IRQ_NONE;
               end
            end
            ST_PEND: begin
               if (interrupt_done) begin
                  r_state   <= ST_ACK;
                  r_irq_vec <= IRQ_NONE;
               end else begin
                  r_irq_vec <= IRQ_KEY;
               end
            end
            ST_ACK: begin
               r_irq_vec <= IRQ_NONE;
               if (!interrupt_done) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_irq_vec <= IRQ_NONE;
            end
         endcase
      end
   end

   // Character output: one-cycle strobe after each art write access
   always_ff @(posedge clk) begin
      if (reset) begin
         r_art_valid <= 1'b0;
         r_art_data  <= 8'h00;
      end else begin
         r_art_valid <= w_art_wr_acc;
         if (w_art_wr_acc) begin
            r_art_data <= bus_write_data[7:0];
         end
      end
   end

   assign interrupt_vector = r_irq_vec;
   assign art_valid        = r_art_valid;
   assign art_data         = r_art_data;

endmodule

// File: tb/tb_key_irq_ctrl.sv
// Directed bench for key_irq_ctrl with a queue-based reference model.
module tb_key_irq_ctrl;

   localparam int          DEPTH = 8;
   localparam logic [63:0] ART   = 64'h8000_0000;
   localparam logic [63:0] KEY   = 64'h8000_0010;
   localparam logic [63:0] STAT  = 64'h8000_0018;

   logic        clk;
   logic        reset;
   logic        key_valid;
   logic [7:0]  key_data;
   logic [3:0]  interrupt_vector;
   logic        interrupt_done;
   logic [63:0] bus_address;
   logic        bus_read_enable;
   logic        bus_write_enable;
   logic [63:0] bus_write_data;
   logic [63:0] bus_read_data;
   logic        art_valid;
   logic [7:0]  art_data;

   int          n_checks = 0;
   int          n_errors = 0;

   logic [7:0]  m_q[$];
   logic [7:0]  art_q[$];
   logic        m_ovf;

   key_irq_ctrl #(
      .DEPTH     (DEPTH),
      .KEY_BASE  (KEY),
      .ART_BASE  (ART),
      .STAT_BASE (STAT)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .key_valid        (key_valid),
      .key_data         (key_data),
      .interrupt_vector (interrupt_vector),
      .interrupt_done   (interrupt_done),
      .bus_address      (bus_address),
      .bus_read_enable  (bus_read_enable),
      .bus_write_enable (bus_write_enable),
      .bus_write_data   (bus_write_data),
      .bus_read_data    (bus_read_data),
      .art_valid        (art_valid),
      .art_data         (art_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Art scoreboard: every strobe must match the oldest expected byte
   always @(negedge clk) begin
      logic [7:0] e;
      if (art_valid === 1'b1) begin
         n_checks++;
         assert (art_q.size() > 0) else begin
            n_errors++;
            $error("FAIL art_spurious observed=%0h expected=none", art_data);
         end
         if (art_q.size() > 0) begin
            e = art_q.pop_front();
            n_checks++;
            assert (art_data === e) else begin
               n_errors++;
               $error("FAIL art_data observed=%0h expected=%0h", art_data, e);
            end
         end
      end
   end

   function automatic logic [63:0] stat_exp();
      logic [63:0] w;
      w       = '0;
      w[15:8] = 8'(m_q.size());
      w[1]    = m_ovf;
      w[0]    = (m_q.size() == 0);
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic m_push(input logic [7:0] d);
      if (m_q.size() == DEPTH) m_ovf = 1'b1;
      else m_q.push_back(d);
   endtask

   task automatic push_key(input logic [7:0] d);
      key_valid = 1'b1;
      key_data  = d;
      m_push(d);
      tick();
      key_valid = 1'b0;
   endtask

   task automatic read_key(input string tag);
      logic [7:0] e;
      bus_address     = KEY;
      bus_read_enable = 1'b1;
      #1;
      e = (m_q.size() > 0) ? m_q.pop_front() : 8'h00;
      check(tag, bus_read_data, {56'b0, e});
      tick();
      bus_read_enable = 1'b0;
      tick();
   endtask

   task automatic read_stat(input string tag);
      bus_address     = STAT;
      bus_read_enable = 1'b1;
      #1;
      check(tag, bus_read_data, stat_exp());
      tick();
      bus_read_enable = 1'b0;
      tick();
   endtask

   task automatic bus_write(input logic [63:0] addr, input logic [63:0] data, input int hold);
      bus_address      = addr;
      bus_write_data   = data;
      bus_write_enable = 1'b1;
      if (addr == ART) art_q.push_back(data[7:0]);
      if (addr == STAT && data[1]) m_ovf = 1'b0;
      repeat (hold) tick();
      bus_write_enable = 1'b0;
      tick();
   endtask

   initial begin
      reset            = 1'b1;
      key_valid        = 1'b0;
      key_data         = 8'h00;
      interrupt_done   = 1'b0;
      bus_address      = '0;
      bus_read_enable  = 1'b0;
      bus_write_enable = 1'b0;
      bus_write_data   = '0;
      m_ovf            = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      check("rst_vector", 64'(interrupt_vector), 64'd0);
      check("rst_art_valid", 64'(art_valid), 64'd0);
      check("rst_art_data", 64'(art_data), 64'd0);
      read_stat("rst_status");

      // Single key: interrupt two cycles after the strobe, read, handshake
      push_key(8'h41);
      check("irq_early", 64'(interrupt_vector), 64'd0);
      tick();
      check("irq_raised", 64'(interrupt_vector), 64'd1);
      read_key("key_41");
      read_stat("stat_after_41");
      interrupt_done = 1'b1;
      tick();
      check("irq_ack", 64'(interrupt_vector), 64'd0);
      interrupt_done = 1'b0;
      tick();
      tick();
      check("irq_idle_empty", 64'(interrupt_vector), 64'd0);

      // Overflow: nine keys into eight slots
      for (int i = 1; i <= 9; i++) push_key(8'(i));
      read_stat("stat_ovf_full");
      check("stat_ovf_literal", stat_exp(), 64'h802);

      // Handshake with keys still queued re-raises after ACK->IDLE
      check("irq_pend_full", 64'(interrupt_vector), 64'd1);
      interrupt_done = 1'b1;
      tick();
      check("irq_ack_full", 64'(interrupt_vector), 64'd0);
      tick();
      tick();
      check("irq_done_held", 64'(interrupt_vector), 64'd0);
      interrupt_done = 1'b0;
      tick();
      check("irq_back_idle", 64'(interrupt_vector), 64'd0);
      tick();
      check("irq_reenter", 64'(interrupt_vector), 64'd1);

      for (int i = 1; i <= 8; i++) read_key("key_ovf_order");
      bus_write(STAT, 64'h2, 1);
      read_stat("stat_ovf_cleared");

      // Unmapped accesses and idle strobe
      bus_write(64'h8000_0008, 64'hFF, 1);
      bus_address     = 64'h8000_0008;
      bus_read_enable = 1'b1;
      #1;
      check("unmapped_read", bus_read_data, 64'd0);
      tick();
      bus_read_enable = 1'b0;
      bus_address     = KEY;
      #1;
      check("no_strobe_read", bus_read_data, 64'd0);
      tick();
      read_stat("stat_after_unmapped");

      // Full FIFO: push and pop in the same cycle
      for (int i = 0; i < 8; i++) push_key(8'hA0 + 8'(i));
      key_valid       = 1'b1;
      key_data        = 8'hA8;
      bus_address     = KEY;
      bus_read_enable = 1'b1;
      #1;
      check("full_pushpop_head", bus_read_data, {56'b0, m_q[0]});
      void'(m_q.pop_front());
      m_push(8'hA8);
      tick();
      key_valid       = 1'b0;
      bus_read_enable = 1'b0;
      tick();
      read_stat("stat_full_pushpop");
      for (int i = 0; i < 8; i++) read_key("key_full_order");

      // Held read strobe pops only once
      push_key(8'hB1);
      push_key(8'hB2);
      bus_address     = KEY;
      bus_read_enable = 1'b1;
      #1;
      check("held_first", bus_read_data, {56'b0, m_q.pop_front()});
      tick();
      check("held_next_head", bus_read_data, {56'b0, m_q[0]});
      tick();
      tick();
      bus_read_enable = 1'b0;
      tick();
      read_stat("stat_held_read");
      read_key("key_b2");

      // Held art write yields one pulse; data holds afterwards
      bus_write(ART, 64'h1234_5678, 2);
      tick();
      check("art_idle", 64'(art_valid), 64'd0);
      check("art_hold", 64'(art_data), 64'h78);
      check("art_q_drained", 64'(art_q.size()), 64'd0);

      // Reset during PEND discards keys; key_valid in reset ignored
      push_key(8'hC1);
      push_key(8'hC2);
      tick();
      check("irq_before_rst", 64'(interrupt_vector), 64'd1);
      reset     = 1'b1;
      key_valid = 1'b1;
      key_data  = 8'h55;
      m_q.delete();
      m_ovf = 1'b0;
      tick();
      tick();
      reset     = 1'b0;
      key_valid = 1'b0;
      check("irq_after_rst", 64'(interrupt_vector), 64'd0);
      read_stat("stat_after_rst");
      read_key("key_empty_after_rst");
      check("irq_stays_idle", 64'(interrupt_vector), 64'd0);

      tick();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
